// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   state_t   : FSM state encoding (IDLE, RUN, DONE)
//   mode_t    : pattern select codes
//   STEP_W    : width of the step index (14 steps max)
//   step_count: number of steps in each pattern
//   pattern   : LED value for a (mode, step) pair
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_WALK_L = 2'd0,
    MODE_WALK_R = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam int STEP_W = 4;

  function automatic logic [STEP_W-1:0] step_count(input mode_t m);
    logic [STEP_W-1:0] n;
    case (m)
      MODE_BOUNCE: n = 4'd14;
      default:     n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] pattern(input mode_t m, input logic [STEP_W-1:0] s);
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] p;
    lo = 8'h01;
    hi = 8'h80;
    case (m)
      MODE_WALK_L: p = lo << s[2:0];
      MODE_WALK_R: p = hi >> s[2:0];
      // Climb for steps 0..7, then descend: step 8 -> bit 6 ... step 13 -> bit 1.
      MODE_BOUNCE: p = (s < 4'd8) ? (lo << s[2:0]) : (lo << (4'd14 - s));
      default:     p = s[0] ? 8'h00 : 8'hFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/LED bundle of the LED pattern sequencer.
//   start, stop, mode_sel : requests from buttons/switches (master drives)
//   busy, done, pout      : status and LED drive (slave drives)
//   state                 : FSM state, exported for observation
// start and stop are level requests with no ready/ack: start is taken on any
// IDLE cycle where start=1 and stop=0; stop is honoured on every cycle. There
// is no back-pressure; acceptance is visible as busy rising one cycle later.
interface led_pattern_sequencer_if;
  import led_seq_pkg::*;

  logic       start;
  logic       stop;
  logic [1:0] mode_sel;
  logic       busy;
  logic       done;
  logic [7:0] pout;
  state_t     state;

  modport master (output start, stop, mode_sel, input busy, done, pout, state);
  modport slave  (input start, stop, mode_sel, output busy, done, pout, state);
endinterface

// File: rtl/tick_divider.sv
// Step-rate prescaler. Counts 0..TICK_DIV-1 while en is high and pulses tick
// on the terminal count, so each step lasts exactly TICK_DIV cycles.
//   clk, rst (async, active-low), en (count), clr (sync clear, wins over en)
//   tick : high while the counter sits at TICK_DIV-1 and en is high
module tick_divider #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: on start, steps the 8-bit LED bank through one of
// four patterns at a rate of one step per TICK_DIV clocks, then pulses done.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   io  : slave side of led_pattern_sequencer_if (start/stop/mode_sel in,
//         busy/done/pout/state out); all outputs are registered.
// Build option LED_SEQ_LOOP_EN: the pattern repeats forever instead of ending,
// pulsing done on every wrap; only stop or reset ends the run.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input logic                     clk,
  input logic                     rst,
  led_pattern_sequencer_if.slave  io
);

  state_t            state;
  mode_t             mode_q;
  logic [STEP_W-1:0] step;
  logic [7:0]        pout_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              last_step;

  // Prescaler is held at zero outside RUN so every run starts on a fresh step.
  tick_divider #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == RUN),
    .clr  (state != RUN),
    .tick (tick)
  );

  assign last_step = (step == step_count(mode_q) - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= MODE_WALK_L;
      step   <= '0;
      pout_q <= 8'h00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start && !io.stop) begin
            state  <= RUN;
            mode_q <= mode_t'(io.mode_sel);
            step   <= '0;
            pout_q <= pattern(mode_t'(io.mode_sel), '0);
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (io.stop) begin
            state  <= IDLE;
            step   <= '0;
            pout_q <= 8'h00;
            busy_q <= 1'b0;
          end else if (tick) begin
            if (last_step) begin
`ifdef LED_SEQ_LOOP_EN
              step   <= '0;
              pout_q <= pattern(mode_q, '0);
              done_q <= 1'b1;
`else
              state  <= DONE;
              step   <= '0;
              pout_q <= 8'h00;
              busy_q <= 1'b0;
              done_q <= 1'b1;
`endif
            end else begin
              step   <= step + 4'd1;
              pout_q <= pattern(mode_q, step + 4'd1);
            end
          end
        end
        // Single-cycle state; the done pulse was already registered on entry.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.state = state;
  assign io.busy  = busy_q;
  assign io.done  = done_q;
  assign io.pout  = pout_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer with TICK_DIV=4.
// Cycle numbering: inputs are applied in cycle 0; cycle n is observed 1 ns
// after the n-th following rising edge.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pattern_sequencer_if io ();

  led_pattern_sequencer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] mode;
    int         cyc;
    logic [7:0] pout;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] p, input logic b, input logic d);
    chk({name, ".pout"}, 32'(io.pout), 32'(p));
    chk({name, ".busy"}, 32'(io.busy), 32'(b));
    chk({name, ".done"}, 32'(io.done), 32'(d));
  endtask

  function automatic void add(input logic [1:0] m, input int c, input logic [7:0] p,
                              input logic b, input logic d);
    vec_t v;
    v.mode = m; v.cyc = c; v.pout = p; v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  // One start pulse in mode m, then ncyc observed cycles checked against the
  // table. With scramble, mode_sel is changed to 3 mid-run.
  task automatic run_table(input logic [1:0] m, input int ncyc, input bit scramble);
    io.mode_sel = m;
    io.start    = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      adv();
      if (c == 1) io.start = 1'b0;
      if (scramble && c == 3) io.mode_sel = 2'd3;
      foreach (vecs[i]) begin
        if (vecs[i].mode == m && vecs[i].cyc == c)
          chk_out($sformatf("mode%0d_c%0d", m, c), vecs[i].pout, vecs[i].busy, vecs[i].done);
      end
    end
  endtask

  initial begin
    io.start    = 1'b0;
    io.stop     = 1'b0;
    io.mode_sel = 2'd0;

`ifndef LED_SEQ_LOOP_EN
    // walk-left
    add(0, 1, 8'h01, 1, 0); add(0, 4, 8'h01, 1, 0); add(0, 5, 8'h02, 1, 0);
    add(0, 9, 8'h04, 1, 0); add(0, 16, 8'h08, 1, 0); add(0, 17, 8'h10, 1, 0);
    add(0, 29, 8'h80, 1, 0); add(0, 32, 8'h80, 1, 0);
    add(0, 33, 8'h00, 0, 1); add(0, 34, 8'h00, 0, 0);
    // walk-right
    add(1, 1, 8'h80, 1, 0); add(1, 5, 8'h40, 1, 0); add(1, 9, 8'h20, 1, 0);
    add(1, 32, 8'h01, 1, 0); add(1, 33, 8'h00, 0, 1);
    // bounce (mode_sel scrambled mid-run)
    add(2, 1, 8'h01, 1, 0); add(2, 29, 8'h80, 1, 0); add(2, 33, 8'h40, 1, 0);
    add(2, 37, 8'h20, 1, 0); add(2, 53, 8'h02, 1, 0); add(2, 56, 8'h02, 1, 0);
    add(2, 57, 8'h00, 0, 1); add(2, 58, 8'h00, 0, 0);
    // blink
    add(3, 1, 8'hFF, 1, 0); add(3, 5, 8'h00, 1, 0); add(3, 9, 8'hFF, 1, 0);
    add(3, 29, 8'h00, 1, 0); add(3, 33, 8'h00, 0, 1); add(3, 34, 8'h00, 0, 0);
`endif

    // reset state
    #3;
    chk_out("reset", 8'h00, 0, 0);
    chk("reset.state", 32'(io.state), 32'(IDLE));
    adv(); adv();
    rst = 1'b1;
    adv();
    chk("idle_no_start.busy", 32'(io.busy), 32'(0));

`ifndef LED_SEQ_LOOP_EN
    run_table(2'd0, 34, 1'b0);
    chk("walk_l_end.state", 32'(io.state), 32'(IDLE));
    run_table(2'd1, 34, 1'b0);
    run_table(2'd2, 58, 1'b1);
    run_table(2'd3, 34, 1'b0);

    // stop mid-run: walk-right, stop at cycle 10
    io.mode_sel = 2'd1;
    io.start    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      adv();
      if (c == 1) io.start = 1'b0;
    end
    chk("stop_c10.pout", 32'(io.pout), 32'h20);
    io.stop = 1'b1;
    adv();
    io.stop = 1'b0;
    chk_out("stop_c11", 8'h00, 0, 0);
    chk("stop_c11.state", 32'(io.state), 32'(IDLE));
    adv();
    chk("stop_c12.done", 32'(io.done), 32'(0));

    // start and stop together in IDLE: no run
    io.start = 1'b1;
    io.stop  = 1'b1;
    adv();
    io.start = 1'b0;
    io.stop  = 1'b0;
    chk_out("start_stop", 8'h00, 0, 0);
    chk("start_stop.state", 32'(io.state), 32'(IDLE));

    // blink with start held: one IDLE cycle then a new run
    io.mode_sel = 2'd3;
    io.start    = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      adv();
      if (c == 5)  chk("held_c5.pout", 32'(io.pout), 32'h00);
      if (c == 33) chk_out("held_c33", 8'h00, 0, 1);
      if (c == 34) chk("held_c34.state", 32'(io.state), 32'(IDLE));
    end
    chk_out("held_c35", 8'hFF, 1, 0);
    io.start = 1'b0;
    io.stop  = 1'b1;
    adv();
    io.stop = 1'b0;
    chk_out("held_stop", 8'h00, 0, 0);
`else
    // looping walk-left
    io.mode_sel = 2'd0;
    io.start    = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      adv();
      if (c == 1)  io.start = 1'b0;
      if (c == 32) chk_out("loop_c32", 8'h80, 1, 0);
      if (c == 33) chk_out("loop_c33", 8'h01, 1, 1);
      if (c == 34) chk_out("loop_c34", 8'h01, 1, 0);
      if (c == 37) chk_out("loop_c37", 8'h02, 1, 0);
      if (c == 64) chk_out("loop_c64", 8'h80, 1, 0);
    end
    chk_out("loop_c65", 8'h01, 1, 1);
    io.stop = 1'b1;
    adv();
    io.stop = 1'b0;
    chk_out("loop_stop", 8'h00, 0, 0);
    chk("loop_stop.state", 32'(io.state), 32'(IDLE));
`endif

    // async reset mid-run: outputs clear before the next clock edge
    io.mode_sel = 2'd0;
    io.start    = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      adv();
      if (c == 1) io.start = 1'b0;
    end
    chk("pre_reset.pout", 32'(io.pout), 32'h02);
    rst = 1'b0;
    #1;
    chk_out("async_reset", 8'h00, 0, 0);
    chk("async_reset.state", 32'(io.state), 32'(IDLE));
    #1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) adv();
    chk_out("post_reset_idle", 8'h00, 0, 0);
    chk("post_reset_idle.state", 32'(io.state), 32'(IDLE));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
